// File: rtl/cache_mem_pkg.sv
// Shared types and default sizing for the cache memory responder.
package cache_mem_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_DEPTH_WORDS = 1024;
    localparam int unsigned BYTE_OFF_W      = $clog2(DEF_DATA_WIDTH / 8);
    localparam int unsigned IDX_W           = $clog2(DEF_DEPTH_WORDS);
    localparam int unsigned CNT_W           = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/cache_mem_sram.sv
// Single-port synchronous word RAM; rdata is registered and reads as zero
// in any cycle that follows a non-read access.
module cache_mem_sram
    import cache_mem_pkg::*;
#(
    parameter int unsigned AW = IDX_W,
    parameter int unsigned DW = DEF_DATA_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] idx_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[idx_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache wrapper: SRAM-backed, programmable
// wait states, sticky protocol checker and completion counters.
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned LAT_WIDTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  mem_valid_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0] mem_adr_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    output logic                  mem_ready_o,
    output logic [DATA_WIDTH-1:0] mem_rdata_o,
    input  logic [LAT_WIDTH-1:0]  lat_cfg_i,
    output logic                  proto_err_o,
    output logic [CNT_W-1:0]      rd_cnt_o,
    output logic [CNT_W-1:0]      wr_cnt_o
);

    localparam int unsigned OFF_W = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IW    = $clog2(DEPTH_WORDS);

    state_e                state_q, state_d;
    logic [LAT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  ready_q;
    logic                  err_q;
    logic [CNT_W-1:0]      rd_cnt_q, wr_cnt_q;

    logic                  ram_en_c, ram_we_c;
    logic [IW-1:0]         ram_idx_c;
    logic [DATA_WIDTH-1:0] ram_wdata_c;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  proto_bad_c;

    // Any deviation from the held request while a transfer is in flight.
    assign proto_bad_c = !mem_valid_i || (mem_we_i != we_q) ||
                         (mem_adr_i != adr_q) || (mem_wdata_i != wdata_q);

    // Next state and SRAM strobes; the zero-latency read uses the live address.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ram_en_c    = 1'b0;
        ram_we_c    = 1'b0;
        ram_idx_c   = adr_q[OFF_W +: IW];
        ram_wdata_c = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (mem_valid_i) begin
                    cnt_d = lat_cfg_i;
                    if (lat_cfg_i == '0) begin
                        state_d   = RESP;
                        ram_en_c  = !mem_we_i;
                        ram_idx_c = mem_adr_i[OFF_W +: IW];
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - LAT_WIDTH'(1);
                if (cnt_q == LAT_WIDTH'(1)) begin
                    state_d  = RESP;
                    ram_en_c = !we_q;
                end
            end
            RESP: begin
                state_d  = IDLE;
                ram_en_c = we_q;
                ram_we_c = we_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == RESP);
            if (state_q == IDLE && mem_valid_i) begin
                we_q    <= mem_we_i;
                adr_q   <= mem_adr_i;
                wdata_q <= mem_wdata_i;
            end
            if (state_q != IDLE && proto_bad_c) begin
                err_q <= 1'b1;
            end
            if (state_q == RESP) begin
                if (we_q) begin
                    wr_cnt_q <= wr_cnt_q + CNT_W'(1);
                end else begin
                    rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    cache_mem_sram #(
        .AW (IW),
        .DW (DATA_WIDTH)
    ) u_sram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (ram_en_c),
        .we_i    (ram_we_c),
        .idx_i   (ram_idx_c),
        .wdata_i (ram_wdata_c),
        .rdata_o (ram_rdata)
    );

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = ram_rdata;
    assign proto_err_o = err_q;
    assign rd_cnt_o    = rd_cnt_q;
    assign wr_cnt_o    = wr_cnt_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: vector table plus corner sequences.
module tb_cache_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_we;
    logic [15:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [3:0]  lat_cfg;
    logic        proto_err;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_rd  = 16'h0;
    logic [15:0] exp_wr  = 16'h0;
    logic        exp_err = 1'b0;

    cache_mem_responder dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mem_valid_i (mem_valid),
        .mem_we_i    (mem_we),
        .mem_adr_i   (mem_adr),
        .mem_wdata_i (mem_wdata),
        .mem_ready_o (mem_ready),
        .mem_rdata_o (mem_rdata),
        .lat_cfg_i   (lat_cfg),
        .proto_err_o (proto_err),
        .rd_cnt_o    (rd_cnt),
        .wr_cnt_o    (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [31:0] wdata;
        logic [3:0]  lat;
        int          exp_cyc;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request; counts posedges from the accept edge until ready is seen.
    // lat_chg_at/drop_at: posedge index after which lat_cfg goes to 0 / valid drops.
    task automatic do_req(input logic we, input logic [15:0] adr, input logic [31:0] wd,
                          input logic [3:0] lat, input int lat_chg_at, input int drop_at,
                          output int cyc, output logic [31:0] rd);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_we    = we;
        mem_adr   = adr;
        mem_wdata = wd;
        lat_cfg   = lat;
        cyc = -1;
        rd  = 32'h0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                cyc = n;
                rd  = mem_rdata;
                break;
            end
            if (n == lat_chg_at) lat_cfg = 4'd0;
            if (n == drop_at) mem_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        check("ready_one_cycle", 32'(mem_ready), 32'h0);
        if (cyc > 0) begin
            if (we) exp_wr = exp_wr + 16'd1;
            else    exp_rd = exp_rd + 16'd1;
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(exp_rd));
        check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(exp_wr));
        check({tag, "_proto_err"}, 32'(proto_err), 32'(exp_err));
    endtask

    initial begin
        int          cyc;
        logic [31:0] rd;
        int          pulses, last, wbad, sbad, seen;
        logic        prev;

        vecs[0] = '{1'b1, 16'h0040, 32'hDEADBEEF, 4'd0, 1, 32'h0};
        vecs[1] = '{1'b0, 16'h0040, 32'h0,        4'd0, 1, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 16'h0010, 32'h12345678, 4'd2, 3, 32'h0};
        vecs[3] = '{1'b0, 16'h0010, 32'h0,        4'd5, 6, 32'h12345678};
        vecs[4] = '{1'b1, 16'h0004, 32'h11111111, 4'd1, 2, 32'h0};
        vecs[5] = '{1'b0, 16'h1004, 32'h0,        4'd0, 1, 32'h11111111};
        vecs[6] = '{1'b0, 16'h0007, 32'h0,        4'd3, 4, 32'h11111111};
        vecs[7] = '{1'b1, 16'hFFFC, 32'hAAAA5555, 4'd0, 1, 32'h0};
        vecs[8] = '{1'b0, 16'h0FFC, 32'h0,        4'd0, 1, 32'hAAAA5555};

        rst_n = 1'b0; mem_valid = 1'b0; mem_we = 1'b0;
        mem_adr = 16'h0; mem_wdata = 32'h0; lat_cfg = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(mem_ready), 32'h0);
        check("reset_rdata", mem_rdata, 32'h0);
        check_counts("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].we, vecs[i].adr, vecs[i].wdata, vecs[i].lat, -1, -1, cyc, rd);
            check($sformatf("vec%0d_latency", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check_counts($sformatf("vec%0d", i));
        end

        // lat_cfg dropped to 0 mid-wait must not shorten the request
        do_req(1'b0, 16'h0010, 32'h0, 4'd5, 2, -1, cyc, rd);
        check("latchg_latency", 32'(cyc), 32'd6);
        check("latchg_rdata", rd, 32'h12345678);
        check_counts("latchg");

        // valid dropped in the second wait cycle: completes, flags error
        do_req(1'b0, 16'h0010, 32'h0, 4'd3, -1, 2, cyc, rd);
        exp_err = 1'b1;
        check("drop_latency", 32'(cyc), 32'd4);
        check("drop_rdata", rd, 32'h12345678);
        check_counts("drop");
        do_req(1'b0, 16'h0040, 32'h0, 4'd1, -1, -1, cyc, rd);
        check("sticky_latency", 32'(cyc), 32'd2);
        check("sticky_rdata", rd, 32'hDEADBEEF);
        check_counts("sticky");

        // reset during the wait of a write: no pulse, no commit
        do_req(1'b1, 16'h0080, 32'h0, 4'd0, -1, -1, cyc, rd);
        check("clr80_latency", 32'(cyc), 32'd1);
        @(negedge clk);
        mem_valid = 1'b1; mem_we = 1'b1; mem_adr = 16'h0080;
        mem_wdata = 32'hCAFEF00D; lat_cfg = 4'd4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        mem_valid = 1'b0;
        exp_rd = 16'h0; exp_wr = 16'h0; exp_err = 1'b0;
        check("midrst_ready", 32'(mem_ready), 32'h0);
        check("midrst_rdata", mem_rdata, 32'h0);
        check_counts("midrst");
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (mem_ready) seen++;
        end
        check("midrst_no_pulse", 32'(seen), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, 16'h0080, 32'h0, 4'd0, -1, -1, cyc, rd);
        check("post_rst_latency", 32'(cyc), 32'd1);
        check("post_rst_rdata", rd, 32'h0);
        check_counts("post_rst");

        // 65536 back-to-back reads at latency 0: counter wraps to its start
        @(negedge clk);
        mem_valid = 1'b1; mem_we = 1'b0; mem_adr = 16'h0080;
        mem_wdata = 32'h0; lat_cfg = 4'd0;
        pulses = 0; last = -10; wbad = 0; sbad = 0; prev = 1'b0;
        for (int c = 1; c <= 140000 && pulses < 65536; c++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                if (prev) wbad++;
                if (c - last < 2) sbad++;
                last = c;
                pulses++;
            end
            prev = mem_ready;
        end
        @(posedge clk); #1;
        mem_valid = 1'b0;
        exp_rd = exp_rd + 16'(pulses);
        check("wrap_pulses", 32'(pulses), 32'd65536);
        check("wrap_width_violations", 32'(wbad), 32'h0);
        check("wrap_spacing_violations", 32'(sbad), 32'h0);
        check("wrap_ready_low", 32'(mem_ready), 32'h0);
        check_counts("wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
